prefix_subtractor_seq: RTL and testbench
========================================

PREFIX_SUBTRACTOR_SEQ -- requirements
Module: prefix_subtractor_seq

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 4, meaning maximum bytes per multi-byte word (2..8).
REQ-002 SHALL have port clock  input  1  rising-edge clock, the single clock domain.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port enable  input  1  block enable; low freezes all state.
REQ-005 SHALL have port in_valid  input  1  operand byte valid.
REQ-006 SHALL have port in_ready  output  1  operand byte accepted when in_valid and in_ready are both high.
REQ-007 SHALL have port in_first  input  1  byte is the least-significant byte of a word.
REQ-008 SHALL have port in_last  input  1  byte is the most-significant byte of a word.
REQ-009 SHALL have port minuend  input  8  minuend byte.
REQ-010 SHALL have port subtrahend  input  8  subtrahend byte.
REQ-011 SHALL have port out_valid  output  1  result byte valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result byte.
REQ-013 SHALL have port diff  output  8  difference byte.
REQ-014 SHALL have port out_borrow  output  1  borrow out of this byte.
REQ-015 SHALL have port out_last  output  1  final byte of the word.
REQ-016 SHALL have port out_zero  output  1  whole word is zero; valid only when out_last is high.
REQ-017 SHALL have port out_err  output  1  framing error on this byte.

Function
REQ-018 SHALL compute {borrow_o, diff} = minuend + ~subtrahend + ~borrow_in.
- Carry generation uses an 8-bit Sklansky generate/propagate prefix tree.
- The prefix tree is written in AND-INV form.
- borrow_o = ~carry_out.
REQ-019 SHALL have a latency of exactly 1 cycle: a byte accepted at edge N drives out_valid, diff and the flags from edge N onward.
REQ-020 SHALL drive in_ready = enable & (~out_valid | out_ready), giving full throughput with no bubble on a simultaneous drain and accept.
REQ-021 SHALL hold diff and all out_* flags stable while out_valid & ~out_ready.
REQ-022 SHALL implement a two-state FSM:
- IDLE: no word in progress.
- IN_WORD: a word is in progress, with a borrow register and a byte counter.
REQ-023 SHALL, on an accept with in_first:
- use borrow_in = 0 and set the counter to 1;
- go to IN_WORD, or to IDLE if in_last is also high.
- This applies in either state; a partial word in progress is abandoned silently.
REQ-024 SHALL, on an accept in IN_WORD without in_first:
- use borrow_in = the borrow register;
- increment the counter;
- go to IDLE if in_last.
REQ-025 SHALL, on an accept in IDLE without in_first, treat the byte as a first byte (borrow_in = 0) and set out_err = 1 for that byte.
REQ-026 SHALL, on the MAX_BYTES-th byte without in_last:
- force out_last = 1 and out_err = 1;
- return to IDLE.
REQ-027 SHALL update the borrow register with borrow_o on every accept.
REQ-028 SHALL accumulate a word-zero flag (AND of diff == 0 across the word) and present it on out_zero when out_last = 1; out_zero = 0 otherwise.
REQ-029 SHALL, while enable = 0:
- accept nothing;
- keep out_valid, diff, the flags and the FSM unchanged;
- ignore out_ready.

Reset
REQ-030 SHALL, while reset_n = 0, asynchronously clear out_valid, diff, out_borrow, out_last, out_zero, out_err, the borrow register and the counter, and set the FSM to IDLE.
REQ-031 SHALL drive in_ready = 0 during reset; reset mid-word discards the word with no output.

Verification
REQ-032 SHALL cover single byte 0x05-0x03 with first=last=1 -> next cycle diff=0x02, borrow=0, last=1, zero=0, err=0.
REQ-033 SHALL cover two-byte 0x0100-0x0001:
- byte0 0x00-0x01 -> diff=0xFF, borrow=1;
- byte1 0x01-0x00 -> diff=0x00, borrow=0, last=1, zero=0.
REQ-034 SHALL cover backpressure: out_ready held low 3 cycles -> in_ready=0 and diff stable; on release, back-to-back bytes complete one per cycle.
REQ-035 SHALL cover reset mid-word after a byte0 giving borrow=1, then a byte 0x10-0x01 without in_first -> diff=0x0F, out_err=1.
REQ-036 SHALL cover MAX_BYTES=4 with five bytes 0x00-0x00 and no in_last -> 4th byte out_last=1, out_err=1, zero=1; the 5th byte is treated per REQ-025.
REQ-037 SHALL cover enable low for 2 cycles with in_valid high -> no accept and outputs frozen; processing resumes correctly when enable returns high.

Source files
------------

// File: rtl/prefix_subtractor_seq.sv
// Byte-serial multi-byte subtractor with a Sklansky prefix-tree carry chain and word framing FSM.
// Latency: one cycle from an accepted operand byte to the registered result byte.
// Backpressure: a single result register; in_ready drops while a result is held unconsumed or enable is low.
module prefix_subtractor_seq #(
  parameter int MAX_BYTES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_first,
  input  logic       in_last,
  input  logic [7:0] minuend,
  input  logic [7:0] subtrahend,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] diff,
  output logic       out_borrow,
  output logic       out_last,
  output logic       out_zero,
  output logic       out_err
);

  // Counter must hold values 0..MAX_BYTES.
  localparam int CW = $clog2(MAX_BYTES + 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_IN_WORD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            borrow_q, borrow_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            zacc_q, zacc_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      diff_q, diff_d;
  logic            out_borrow_q, out_borrow_d;
  logic            out_last_q, out_last_d;
  logic            out_zero_q, out_zero_d;
  logic            out_err_q, out_err_d;

  logic            accept;
  logic            word_start;
  logic            frame_err;
  logic            borrow_in;
  logic [CW-1:0]   cnt_nxt;
  logic            overflow;
  logic            last_w;
  logic            zero_nxt;

  logic [7:0]      sum;
  logic            borrow_o;

  // Reset gating keeps in_ready low while reset is asserted.
  assign in_ready = reset_n & enable & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Word framing decisions for the byte currently on the input.
  always_comb begin
    word_start = in_first | (state_q == S_IDLE);
    frame_err  = ~in_first & (state_q == S_IDLE);
    borrow_in  = word_start ? 1'b0 : borrow_q;
    cnt_nxt    = word_start ? CW'(1) : cnt_q + CW'(1);
    overflow   = (cnt_nxt == CW'(MAX_BYTES)) & ~in_last;
    last_w     = in_last | overflow;
    zero_nxt   = (word_start | zacc_q) & (sum == 8'h00);
  end

  // ---------------------------------------------------------------
  // Adder: minuend + ~subtrahend + ~borrow_in. The carry-in is folded
  // into bit 0's generate so every prefix group reaching bit 0 is the
  // true carry into the next bit.
  // ---------------------------------------------------------------
  logic [7:0] op_a, op_b;
  logic       cin;
  logic [7:0] g_bit, p_bit;
  logic [7:0] gl [0:3];
  logic [7:0] pl [0:2];

  assign op_a  = minuend;
  assign op_b  = ~subtrahend;
  assign cin   = ~borrow_in;
  assign g_bit = op_a & op_b;
  assign p_bit = op_a ^ op_b;

  // g | (p & cin) written as NAND of inverted terms.
  assign gl[0] = {g_bit[7:1], ~(~g_bit[0] & ~(p_bit[0] & cin))};
  assign pl[0] = p_bit;

  // Sklansky levels: node i with bit (l-1) set absorbs the top node of
  // the lower half of its 2^l block.
  for (genvar l = 1; l <= 3; l++) begin : g_lvl
    for (genvar i = 0; i < 8; i++) begin : g_node
      if (((i >> (l - 1)) % 2) == 1) begin : g_black
        localparam int J = ((i >> (l - 1)) << (l - 1)) - 1;
        assign gl[l][i] = ~(~gl[l-1][i] & ~(pl[l-1][i] & gl[l-1][J]));
        if (l < 3) begin : g_prop
          assign pl[l][i] = pl[l-1][i] & pl[l-1][J];
        end
      end else begin : g_pass
        assign gl[l][i] = gl[l-1][i];
        if (l < 3) begin : g_prop
          assign pl[l][i] = pl[l-1][i];
        end
      end
    end
  end

  assign sum      = p_bit ^ {gl[3][6:0], cin};
  assign borrow_o = ~gl[3][7];

  // Next-state, word bookkeeping and result register loads.
  always_comb begin
    state_d      = state_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    zacc_d       = zacc_q;
    out_valid_d  = out_valid_q;
    diff_d       = diff_q;
    out_borrow_d = out_borrow_q;
    out_last_d   = out_last_q;
    out_zero_d   = out_zero_q;
    out_err_d    = out_err_q;
    if (accept) begin
      state_d      = last_w ? S_IDLE : S_IN_WORD;
      borrow_d     = borrow_o;
      cnt_d        = cnt_nxt;
      zacc_d       = zero_nxt;
      out_valid_d  = 1'b1;
      diff_d       = sum;
      out_borrow_d = borrow_o;
      out_last_d   = last_w;
      out_zero_d   = last_w & zero_nxt;
      out_err_d    = frame_err | overflow;
    end else if (enable && out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      zacc_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      diff_q       <= 8'h00;
      out_borrow_q <= 1'b0;
      out_last_q   <= 1'b0;
      out_zero_q   <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      zacc_q       <= zacc_d;
      out_valid_q  <= out_valid_d;
      diff_q       <= diff_d;
      out_borrow_q <= out_borrow_d;
      out_last_q   <= out_last_d;
      out_zero_q   <= out_zero_d;
      out_err_q    <= out_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign out_borrow = out_borrow_q;
  assign out_last   = out_last_q;
  assign out_zero   = out_zero_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_prefix_subtractor_seq.sv
// Testbench for prefix_subtractor_seq: directed scenarios plus random traffic
// checked against an arithmetic word-level model with an expected-output queue.
module tb_prefix_subtractor_seq;

  localparam int MAXB = 4;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       in_valid;
  logic       in_ready;
  logic       in_first;
  logic       in_last;
  logic [7:0] minuend;
  logic [7:0] subtrahend;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       out_borrow;
  logic       out_last;
  logic       out_zero;
  logic       out_err;

  prefix_subtractor_seq #(.MAX_BYTES(MAXB)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_first   (in_first),
    .in_last    (in_last),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .out_borrow (out_borrow),
    .out_last   (out_last),
    .out_zero   (out_zero),
    .out_err    (out_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int tests = 0;
  int fails = 0;

  // Reference model: word-level state and a queue of expected result bytes
  // packed as {diff, borrow, last, zero, err}.
  bit          m_in_word;
  int          m_cnt;
  bit          m_borrow;
  bit          m_zero;
  logic [11:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_in_word = 1'b0;
    m_cnt     = 0;
    m_borrow  = 1'b0;
    m_zero    = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_accept(input logic f, input logic l, input logic [7:0] m, input logic [7:0] s);
    int bin;
    int t;
    bit err;
    bit lastx;
    logic [7:0] d;
    bit br;
    if (f || !m_in_word) begin
      bin = 0; m_cnt = 1; m_zero = 1'b1; err = !f;
    end else begin
      bin = int'(m_borrow); m_cnt = m_cnt + 1; err = 1'b0;
    end
    t      = int'(m) - int'(s) - bin;
    d      = t[7:0];
    br     = (t < 0);
    m_zero = m_zero && (d == 8'h00);
    lastx  = l || (m_cnt == MAXB);
    err    = err || (m_cnt == MAXB && !l);
    m_in_word = !lastx;
    m_borrow  = br;
    exp_q.push_back({d, br, lastx, lastx && m_zero, err});
  endfunction

  // One clock cycle: drive at the falling edge, check handshake state, and
  // advance the model at the rising edge. Ends 1 time unit after the edge.
  task automatic cyc(input logic v, input logic f, input logic l,
                     input logic [7:0] m, input logic [7:0] s,
                     input logic ordy, input logic en);
    logic exp_rdy;
    logic acc;
    @(negedge clock);
    enable = en; in_valid = v; in_first = f; in_last = l;
    minuend = m; subtrahend = s; out_ready = ordy;
    #1;
    exp_rdy = en && (exp_q.size() == 0 || ordy);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
    if (en && ordy && exp_q.size() != 0) begin
      chk("result", {20'd0, diff, out_borrow, out_last, out_zero, out_err}, {20'd0, exp_q[0]});
      void'(exp_q.pop_front());
    end
    acc = v && exp_rdy;
    @(posedge clock);
    if (acc) model_accept(f, l, m, s);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; enable = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_flags", {27'd0, out_borrow, out_last, out_zero, out_err, 1'b0}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    model_reset();
    @(negedge clock);
    in_valid = 1'b0;
    reset_n  = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; enable = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    minuend = 8'h00; subtrahend = 8'h00; out_ready = 1'b0;
    model_reset();
    #3;
    do_reset();

    // Single byte 0x05 - 0x03.
    cyc(1'b1, 1'b1, 1'b1, 8'h05, 8'h03, 1'b1, 1'b1);
    chk("single_diff", {24'd0, diff}, 32'h02);
    chk("single_flags", {28'd0, out_borrow, out_last, out_zero, out_err}, 32'b0100);
    idle(1);

    // Two-byte 0x0100 - 0x0001.
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 1'b1);
    chk("w2_b0_diff", {24'd0, diff}, 32'hFF);
    chk("w2_b0_borrow", {31'd0, out_borrow}, 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b1, 1'b1);
    chk("w2_b1_diff", {24'd0, diff}, 32'h00);
    chk("w2_b1_flags", {28'd0, out_borrow, out_last, out_zero, out_err}, 32'b0100);
    idle(1);

    // Backpressure: hold a result for three cycles, then stream.
    cyc(1'b1, 1'b1, 1'b0, 8'h33, 8'h11, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h44, 8'h22, 1'b0, 1'b1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_diff_stable", {24'd0, diff}, 32'h22);
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h44, 8'h22, 1'b1, 1'b1);
    chk("bp_b1_diff", {24'd0, diff}, 32'h22);
    cyc(1'b1, 1'b0, 1'b1, 8'h10, 8'h20, 1'b1, 1'b1);
    chk("bp_b2_diff", {24'd0, diff}, 32'hF0);
    chk("bp_b2_borrow", {31'd0, out_borrow}, 32'd1);
    idle(1);

    // Reset mid-word, then a non-first byte must be a fresh first byte with err.
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1);
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h10, 8'h01, 1'b1, 1'b1);
    chk("rst_mid_diff", {24'd0, diff}, 32'h0F);
    chk("rst_mid_err", {31'd0, out_err}, 32'd1);

    // Five zero bytes with no in_last: overflow on the 4th, framing err on the 5th.
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    chk("ovf_flags", {29'd0, out_last, out_err, out_zero}, 32'b111);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    chk("ovf_next_flags", {29'd0, out_last, out_err, out_zero}, 32'b010);
    idle(1);

    // Enable low freezes everything, including out_ready handling.
    cyc(1'b1, 1'b1, 1'b1, 8'h80, 8'h01, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b1, 1'b1, 8'h09, 8'h09, 1'b1, 1'b0);
      chk("en_freeze_valid", {31'd0, out_valid}, 32'd1);
      chk("en_freeze_diff", {24'd0, diff}, 32'h7F);
    end
    cyc(1'b1, 1'b1, 1'b1, 8'h09, 8'h09, 1'b1, 1'b1);
    chk("en_resume_diff", {24'd0, diff}, 32'h00);
    chk("en_resume_zero", {31'd0, out_zero}, 32'd1);
    idle(1);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      logic [7:0] rm;
      logic [7:0] rs;
      rs = 8'($urandom_range(0, 255));
      rm = ($urandom_range(0, 9) < 3) ? rs : 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
          rm, rs, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 9));
    end
    idle(3);
    chk("final_drained", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
